// File: rtl/mem_stage_bus_ctrl.sv
// MIPS memory-access stage: issues loads/stores to the shared data memory,
// hands the bus to DMA over HOLD/HLDA and stalls the pipeline while it waits.
module mem_stage_bus_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [2:0]        wb_control_in,
   input  logic [DATA_W-1:0] alu_result_in,
   input  logic [DATA_W-1:0] store_data_in,
   input  logic [4:0]        rd_in,
   input  logic [14:0]       pc_in,
   input  logic              hold,
   output logic              hlda,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall,
   output logic [2:0]        control_out,
   output logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] alu_output_out,
   output logic [4:0]        rd_out,
   output logic [14:0]       pc_out
);

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
   localparam logic [1:0] ST_DMA_GRANT = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              hlda_q, hlda_d;
   logic [2:0]        ctrl_q, ctrl_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [4:0]        rd_q, rd_d;
   logic [14:0]       pc_q, pc_d;

   // Next-state, load capture and all combinational bus / MEM-WB outputs.
   always_comb begin
      state_d        = state_q;
      hlda_d         = 1'b0;
      ctrl_d         = ctrl_q;
      alu_d          = alu_q;
      rd_d           = rd_q;
      pc_d           = pc_q;
      hlda           = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      mem_we         = 1'b0;
      mem_re         = 1'b0;
      stall          = 1'b0;
      control_out    = 3'b000;
      mem_data_out   = '0;
      alu_output_out = '0;
      rd_out         = 5'd0;
      pc_out         = 15'd0;
      if (rst) begin
         state_d = ST_RUN;
      end else begin
         hlda = hlda_q;
         case (state_q)
            ST_RUN: begin
               mem_addr  = alu_result_in[ADDR_W+1:2];
               mem_wdata = store_data_in;
               // A DMA request wins over whatever sits in EX/MEM; it is replayed later.
               if (hold) begin
                  stall   = 1'b1;
                  hlda_d  = 1'b1;
                  state_d = ST_DMA_GRANT;
               end else if (valid_in && mem_read_in) begin
                  mem_re  = 1'b1;
                  stall   = 1'b1;
                  ctrl_d  = wb_control_in;
                  alu_d   = alu_result_in;
                  rd_d    = rd_in;
                  pc_d    = pc_in;
                  state_d = ST_LOAD_WAIT;
               end else if (valid_in) begin
                  mem_we         = mem_write_in;
                  control_out    = wb_control_in;
                  alu_output_out = alu_result_in;
                  rd_out         = rd_in;
                  pc_out         = pc_in;
               end else begin
                  stall = 1'b0;
               end
            end
            ST_LOAD_WAIT: begin
               mem_addr       = alu_result_in[ADDR_W+1:2];
               mem_wdata      = store_data_in;
               mem_data_out   = mem_rdata;
               control_out    = ctrl_q;
               alu_output_out = alu_q;
               rd_out         = rd_q;
               pc_out         = pc_q;
               state_d        = ST_RUN;
            end
            ST_DMA_GRANT: begin
               stall = 1'b1;
               if (hold) begin
                  hlda_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   // State, grant and captured-load registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         hlda_q  <= 1'b0;
         ctrl_q  <= 3'b000;
         alu_q   <= '0;
         rd_q    <= 5'd0;
         pc_q    <= 15'd0;
      end else begin
         state_q <= state_d;
         hlda_q  <= hlda_d;
         ctrl_q  <= ctrl_d;
         alu_q   <= alu_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: doc/mem_stage_bus_ctrl.md
Name: mem_stage_bus_ctrl

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register, and drives the MEM/WB inputs directly.
- Issues loads and stores to the shared synchronous data memory.
- Arbitrates that memory bus against the DMA controller using a HOLD/HLDA handshake.
- Stalls the upstream pipeline while a load waits for its data or while DMA owns the bus.

Parameters:
- DATA_W, 32, data and ALU-result width.
- ADDR_W, 15, word-address width of the data memory.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- valid_in  in  1  EX/MEM slot holds a real instruction (0 = bubble).
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store.
- wb_control_in  in  3  writeback control, passed to MEM/WB.
- alu_result_in  in  DATA_W  effective byte address / ALU result.
- store_data_in  in  DATA_W  store data.
- rd_in  in  5  destination register.
- pc_in  in  15  instruction PC.
- hold  in  1  DMA bus request.
- hlda  out  1  bus granted to DMA (registered).
- mem_addr  out  ADDR_W  word address, equal to alu_result_in[ADDR_W+1:2].
- mem_wdata  out  DATA_W  equal to store_data_in.
- mem_we  out  1  memory write strobe.
- mem_re  out  1  memory read strobe.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- control_out  out  3  to MEM/WB control_in.
- mem_data_out  out  DATA_W  to MEM/WB mem_data_in.
- alu_output_out  out  DATA_W  to MEM/WB alu_output_in.
- rd_out  out  5  to MEM/WB rd_in.
- pc_out  out  15  to MEM/WB pc_in.

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
  - At reset the state is RUN, hlda=0 and the capture registers are 0.
  - While rst=1 every output is 0.
- Bubble: control_out=0. In a bubble, mem_data_out, alu_output_out, rd_out and pc_out are 0.
- FSM states: RUN, LOAD_WAIT, DMA_GRANT.
- RUN with hold=1:
  - Takes priority over any memory operation.
  - No strobe is issued; stall=1; a bubble is presented.
  - Next state DMA_GRANT; hlda rises at the clock edge.
- RUN with hold=0 and no valid memory operation (valid_in=0, or neither mem_read_in nor mem_write_in set):
  - Pass-through.
  - control_out = wb_control_in when valid_in=1, else 0.
  - alu_output_out, rd_out and pc_out come from the inputs; mem_data_out=0.
  - stall=0.
- RUN, valid store (hold=0):
  - mem_we=1 for that cycle only; stall=0.
  - Pass-through as above. There is no store latency.
- RUN, valid load (hold=0):
  - mem_re=1; stall=1; a bubble is presented.
  - wb_control_in, alu_result_in, rd_in and pc_in are captured.
  - Next state LOAD_WAIT.
- LOAD_WAIT:
  - mem_data_out = mem_rdata; the other MEM/WB outputs come from the captured copies.
  - stall=0; mem_re=mem_we=0.
  - Next state RUN. hold is ignored here and sampled next in RUN.
  - Load latency is 2 cycles, with 1 stall cycle.
- mem_read_in and mem_write_in both set: treat as a load; mem_we stays 0.
- DMA_GRANT:
  - hlda=1, stall=1, bubble presented, mem_re=mem_we=0.
  - mem_addr and mem_wdata are 0 (bus released).
  - When hold=0 is sampled: next state RUN and hlda drops at that edge.
  - The held EX/MEM instruction is then processed in RUN.
- hlda is never asserted in the same cycle as mem_re or mem_we.
- hlda is never asserted while LOAD_WAIT is pending.
- Reset mid-operation: from any state, the next state is RUN with hlda=0. An in-flight load is discarded, with no writeback.

Test Plan:
- Reset then ALU instruction: rst 2 cycles, then valid_in=1, alu_result_in=0x0000_0010, rd_in=5, wb_control_in=3'b101, pc_in=0x0004.
  - Same cycle: control_out=3'b101, alu_output_out=0x10, rd_out=5, stall=0, mem_re=mem_we=0.
- Store: mem_write_in=1, alu_result_in=0x20, store_data_in=0xDEADBEEF.
  - mem_we=1 for exactly one cycle, mem_addr=8, mem_wdata=0xDEADBEEF, stall=0.
- Load: mem_read_in=1, alu_result_in=0x20, rd_in=9, memory returns 0xDEADBEEF.
  - Cycle 0: mem_re=1, mem_addr=8, stall=1, control_out=0.
  - Cycle 1: mem_data_out=0xDEADBEEF, rd_out=9, stall=0.
- DMA grant: hold=1 for 4 cycles while a load is in EX/MEM.
  - hlda=1 from the next edge, stall=1 throughout, no mem_re.
  - hlda=0 one edge after hold drops; the load then completes with 2-cycle latency.
- hold asserted during LOAD_WAIT: the load completes first (mem_data_out valid), then hlda=1 on the following edge.
- Reset mid-load: assert rst in LOAD_WAIT.
  - Outputs are 0 and the state is RUN.
  - The next valid ALU instruction passes through with stall=0.
